alarm_sequencer: RTL and testbench
==================================

# alarm_sequencer

Arming/alarm state machine that sequences the motion-detect buzzer path of the intrusion alarm. It consumes the debounced motion level and user arm/disarm pulses, times exit/entry/alarm windows from a prescaled tick, and drives the buzzer with a state-dependent beep pattern. It sits between the motion debouncer and the buzzer pin and replaces direct motion-to-buzzer wiring.

## Interface
- TICK_DIV, 50000: clk cycles per tick (1 ms at 50 MHz); must be ≥2.
- EXIT_TICKS, 10000: exit-delay length in ticks; ≥1.
- ENTRY_TICKS, 5000: entry-delay length in ticks; ≥1.
- ALARM_TICKS, 30000: buzzer-on alarm length in ticks; ≥1.
- EXIT_BEEP, 500: beep half-period in EXIT, in ticks; ≥1.
- ENTRY_BEEP, 125: beep half-period in ENTRY, in ticks; ≥1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- arm  in  1  one-cycle synchronous pulse; request arming.
- disarm  in  1  one-cycle synchronous pulse; request disarming.
- motion  in  1  debounced, synchronous motion level.
- buzzer  out  1  buzzer drive.
- armed  out  1  high in ARMED, ENTRY, ALARM, HOLD.
- alarm_active  out  1  high in ALARM only.
- state  out  3  current state code.
- alarm_count  out  8  number of ALARM entries since reset, saturating at 255.

## Operation
- States/codes: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, HOLD=5; codes 6/7 unreachable, recover to DISARMED.
- Transitions, evaluated each cycle; disarm has priority over every other condition in every state except DISARMED:
  - DISARMED: arm=1 and disarm=0 -> EXIT; otherwise stay.
  - EXIT: timer expiry -> ARMED; motion ignored.
  - ARMED: motion=1 -> ENTRY.
  - ENTRY: timer expiry -> ALARM; alarm_count increments (saturating).
  - ALARM: timer expiry -> HOLD.
  - HOLD: motion=0 -> ARMED; motion=1 -> stay.
  - arm ignored in all states but DISARMED.
- Timer: prescaler (0..TICK_DIV-1) and tick counter both clear on every state change. Prescaler increments each cycle and wraps; each wrap is a tick and increments the tick counter. Expiry in a state with length N is the cycle where prescaler=TICK_DIV-1 and tick counter=N-1.
- Beep phase (EXIT/ENTRY): phase set to 1 on state entry and toggles on each tick where (tick counter+1) is a multiple of that state's BEEP half-period.
- buzzer: DISARMED 0, EXIT phase, ARMED 0, ENTRY phase, ALARM 1, HOLD 0.
- Counter widths: each counter sized by $clog2 of its parameter; no overflow within a state.

## Timing
- Reset (asynchronous): state=DISARMED, buzzer=0, armed=0, alarm_active=0, alarm_count=0, prescaler/tick/phase cleared. Reset mid-operation aborts any window immediately.
- State, buzzer, armed, alarm_active all registered and change on the same clock edge; 1-cycle latency from input sample to output change.
- Dwell in a timed state = N*TICK_DIV cycles exactly, counting the entry cycle.
- EXIT buzzer: 1 for EXIT_BEEP*TICK_DIV cycles, then 0 for the same, repeating. ENTRY uses ENTRY_BEEP.
- disarm and timer expiry in the same cycle -> DISARMED. arm+disarm in DISARMED -> stay DISARMED.
- motion high on the ARMED entry edge (from EXIT or HOLD) -> ENTRY on the following edge.
- alarm_count at 255: ENTRY->ALARM still occurs, count holds 255.

## Test plan
Params for all scenarios: TICK_DIV=4, EXIT_TICKS=3, ENTRY_TICKS=2, ALARM_TICKS=5, EXIT_BEEP=1, ENTRY_BEEP=1.
- Arm pulse, motion=0 -> state=1 next edge; buzzer 1/0/1 for 4 cycles each; state=2 after 12 cycles; armed=1, buzzer=0.
- From ARMED, motion=1 -> state=3 next edge, buzzer 1 for 4 cycles then 0 for 4; state=4 after 8 cycles; alarm_count=1; buzzer=1 and alarm_active=1 for 20 cycles; state=5 with buzzer=0. Drop motion -> state=2 next edge.
- Disarm pulse mid-ALARM -> state=0, buzzer=0, armed=0 next edge. Disarm coincident with EXIT expiry cycle -> state=0.
- arm+disarm same cycle in DISARMED -> state stays 0. Arm pulse during ARMED -> no effect.
- Assert reset asynchronously mid-ENTRY -> all outputs 0 without waiting for a clk edge. Force 256 alarm cycles -> alarm_count=255.

Source files
------------

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
//   Groups the alarm sequencer's control inputs and status outputs.
//   master : drives arm/disarm/motion, observes status (user/debouncer side).
//   slave  : the sequencer itself.
// Signal semantics: arm and disarm are single-cycle synchronous pulses
// sampled on the rising clk edge; motion is a synchronous level. There is no
// valid/ready back-pressure: every input is consumed on the edge it is
// sampled, and every output is a registered level that may be sampled at any
// time away from the rising edge.
//   arm, disarm     : request pulses
//   motion          : debounced motion level
//   buzzer          : buzzer drive
//   armed           : high in ARMED, ENTRY, ALARM, HOLD
//   alarm_active    : high in ALARM only
//   state[2:0]      : current state code
//   alarm_count[7:0]: saturating count of ALARM entries
interface alarm_sequencer_if;
  logic       arm;
  logic       disarm;
  logic       motion;
  logic       buzzer;
  logic       armed;
  logic       alarm_active;
  logic [2:0] state;
  logic [7:0] alarm_count;

  modport master (
    output arm, disarm, motion,
    input  buzzer, armed, alarm_active, state, alarm_count
  );

  modport slave (
    input  arm, disarm, motion,
    output buzzer, armed, alarm_active, state, alarm_count
  );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Arming/alarm state machine for the motion-detect buzzer path. Times the
//   exit, entry and alarm windows from a prescaled tick and drives the buzzer
//   with a state-dependent beep pattern.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : alarm_sequencer_if.slave (arm/disarm/motion in; buzzer, armed,
//           alarm_active, state, alarm_count out)
module alarm_sequencer #(
  parameter int TICK_DIV    = 50000,
  parameter int EXIT_TICKS  = 10000,
  parameter int ENTRY_TICKS = 5000,
  parameter int ALARM_TICKS = 30000,
  parameter int EXIT_BEEP   = 500,
  parameter int ENTRY_BEEP  = 125
) (
  input  logic              clk,
  input  logic              reset,
  alarm_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  localparam int MAX_TICKS_A = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
  localparam int MAX_TICKS   = (MAX_TICKS_A > ALARM_TICKS) ? MAX_TICKS_A : ALARM_TICKS;
  localparam int MAX_BEEP    = (EXIT_BEEP > ENTRY_BEEP) ? EXIT_BEEP : ENTRY_BEEP;
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int BW = (MAX_BEEP > 1) ? $clog2(MAX_BEEP) : 1;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  beep_q, beep_d;
  logic           phase_q, phase_d;
  logic [7:0]     count_q, count_d;
  logic           buzzer_q, buzzer_d;
  logic           armed_q, armed_d;
  logic           active_q, active_d;

  logic           timed;
  logic           tick_w;
  logic           expire;
  logic [TW-1:0]  len_m1;
  logic [BW-1:0]  beep_m1;

  // Window length and beep half-period (both minus one) of the current state.
  always_comb begin
    len_m1  = '0;
    beep_m1 = '0;
    timed   = 1'b0;
    case (state_q)
      S_EXIT: begin
        len_m1  = TW'(EXIT_TICKS - 1);
        beep_m1 = BW'(EXIT_BEEP - 1);
        timed   = 1'b1;
      end
      S_ENTRY: begin
        len_m1  = TW'(ENTRY_TICKS - 1);
        beep_m1 = BW'(ENTRY_BEEP - 1);
        timed   = 1'b1;
      end
      S_ALARM: begin
        len_m1  = TW'(ALARM_TICKS - 1);
        timed   = 1'b1;
      end
      default: ;
    endcase
  end

  assign tick_w = timed && (presc_q == PW'(TICK_DIV - 1));
  assign expire = tick_w && (tick_q == len_m1);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    beep_d   = beep_q;
    phase_d  = phase_q;
    count_d  = count_q;
    buzzer_d = 1'b0;
    armed_d  = 1'b0;
    active_d = 1'b0;

    case (state_q)
      S_DISARMED: if (bus.arm && !bus.disarm) state_d = S_EXIT;
      S_EXIT: begin
        if (bus.disarm)  state_d = S_DISARMED;
        else if (expire) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (bus.disarm)      state_d = S_DISARMED;
        else if (bus.motion) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (bus.disarm) state_d = S_DISARMED;
        else if (expire) begin
          state_d = S_ALARM;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      S_ALARM: begin
        if (bus.disarm)  state_d = S_DISARMED;
        else if (expire) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.disarm)       state_d = S_DISARMED;
        else if (!bus.motion) state_d = S_ARMED;
      end
      default: state_d = S_DISARMED;
    endcase

    // Every state change restarts the window and the beep pattern at "on".
    if (state_d != state_q) begin
      presc_d = '0;
      tick_d  = '0;
      beep_d  = '0;
      phase_d = 1'b1;
    end else if (timed) begin
      presc_d = tick_w ? '0 : presc_q + PW'(1);
      if (tick_w) begin
        tick_d = tick_q + TW'(1);
        // beep_q tracks (tick counter mod half-period) without a divider.
        if (beep_q == beep_m1) begin
          beep_d  = '0;
          phase_d = ~phase_q;
        end else begin
          beep_d = beep_q + BW'(1);
        end
      end
    end

    // Outputs are registered from the next state so they move with state.
    case (state_d)
      S_EXIT, S_ENTRY: buzzer_d = phase_d;
      S_ALARM:         buzzer_d = 1'b1;
      default:         buzzer_d = 1'b0;
    endcase
    armed_d  = (state_d == S_ARMED) || (state_d == S_ENTRY) ||
               (state_d == S_ALARM) || (state_d == S_HOLD);
    active_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_DISARMED;
      presc_q  <= '0;
      tick_q   <= '0;
      beep_q   <= '0;
      phase_q  <= 1'b0;
      count_q  <= 8'd0;
      buzzer_q <= 1'b0;
      armed_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      beep_q   <= beep_d;
      phase_q  <= phase_d;
      count_q  <= count_d;
      buzzer_q <= buzzer_d;
      armed_q  <= armed_d;
      active_q <= active_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.buzzer       = buzzer_q;
  assign bus.armed        = armed_q;
  assign bus.alarm_active = active_q;
  assign bus.alarm_count  = count_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;
  localparam int TICK_DIV    = 4;
  localparam int EXIT_TICKS  = 3;
  localparam int ENTRY_TICKS = 2;
  localparam int ALARM_TICKS = 5;
  localparam int EXIT_BEEP   = 1;
  localparam int ENTRY_BEEP  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .EXIT_TICKS  (EXIT_TICKS),
    .ENTRY_TICKS (ENTRY_TICKS),
    .ALARM_TICKS (ALARM_TICKS),
    .EXIT_BEEP   (EXIT_BEEP),
    .ENTRY_BEEP  (ENTRY_BEEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st, input logic bz,
                            input logic ar, input logic act);
    check({tag, ".state"},  32'(bus.state),        32'(st));
    check({tag, ".buzzer"}, 32'(bus.buzzer),       32'(bz));
    check({tag, ".armed"},  32'(bus.armed),        32'(ar));
    check({tag, ".active"}, 32'(bus.alarm_active), 32'(act));
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_arm();
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    bus.disarm = 1'b1;
    @(negedge clk);
    bus.disarm = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
    int n = 0;
    while (bus.state !== code && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.state), 32'(code));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.arm    = 1'b0;
    bus.disarm = 1'b0;
    bus.motion = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    check("reset.count", 32'(bus.alarm_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    expect_out("idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Arm: EXIT for 12 cycles, buzzer 1/0/1 in 4-cycle blocks.
    pulse_arm();
    for (int i = 0; i < 12; i++) begin
      expect_out("exit", 3'd1, ((i / 4) % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    expect_out("armed", 3'd2, 1'b0, 1'b1, 1'b0);

    // Motion: ENTRY 8 cycles (buzzer 1 then 0), ALARM 20 cycles, HOLD.
    bus.motion = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      expect_out("entry", 3'd3, (i < 4) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    check("count_first", 32'(bus.alarm_count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      expect_out("alarm", 3'd4, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
    end
    expect_out("hold", 3'd5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect_out("hold_stay", 3'd5, 1'b0, 1'b1, 1'b0);
    bus.motion = 1'b0;
    @(negedge clk);
    expect_out("hold_to_armed", 3'd2, 1'b0, 1'b1, 1'b0);

    // Arm ignored in ARMED; then disarm in the middle of ALARM.
    pulse_arm();
    expect_out("arm_ignored", 3'd2, 1'b0, 1'b1, 1'b0);
    bus.motion = 1'b1;
    @(negedge clk);
    repeat (8) @(negedge clk);
    repeat (3) @(negedge clk);
    expect_out("mid_alarm", 3'd4, 1'b1, 1'b1, 1'b1);
    bus.motion = 1'b0;
    pulse_disarm();
    expect_out("disarm_alarm", 3'd0, 1'b0, 1'b0, 1'b0);
    check("count_second", 32'(bus.alarm_count), 32'd2);

    // arm and disarm together while disarmed: stay disarmed.
    bus.arm    = 1'b1;
    bus.disarm = 1'b1;
    @(negedge clk);
    bus.arm    = 1'b0;
    bus.disarm = 1'b0;
    expect_out("arm_and_disarm", 3'd0, 1'b0, 1'b0, 1'b0);

    // Disarm on the EXIT expiry cycle wins; motion is ignored in EXIT.
    pulse_arm();
    bus.motion = 1'b1;
    repeat (11) @(negedge clk);
    expect_out("exit_last", 3'd1, 1'b1, 1'b0, 1'b0);
    pulse_disarm();
    expect_out("disarm_at_expiry", 3'd0, 1'b0, 1'b0, 1'b0);

    // Motion already high when ARMED is entered -> ENTRY on the next edge.
    pulse_arm();
    repeat (12) @(negedge clk);
    expect_out("armed_with_motion", 3'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect_out("entry_from_armed", 3'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-ENTRY, checked before the next rising edge.
    #2 reset = 1'b1;
    #1;
    expect_out("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
    check("async_reset.count", 32'(bus.alarm_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.motion = 1'b0;
    @(negedge clk);

    // Saturation: 255 alarm entries, then one more.
    pulse_arm();
    wait_state(3'd2, 20, "sat_armed");
    for (int n = 0; n < 255; n++) begin
      bus.motion = 1'b1;
      wait_state(3'd5, 40, "sat_hold");
      bus.motion = 1'b0;
      wait_state(3'd2, 5, "sat_back");
    end
    check("count_255", 32'(bus.alarm_count), 32'd255);
    bus.motion = 1'b1;
    wait_state(3'd4, 20, "sat_alarm_again");
    check("count_hold_255", 32'(bus.alarm_count), 32'd255);
    check("sat_active", 32'(bus.alarm_active), 32'd1);
    bus.motion = 1'b0;
    pulse_disarm();
    expect_out("final_disarm", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
